// File: rtl/btn_debounce_evt_pkg.sv
// Shared types, register-map offsets and helpers for the button debounce/event block.
package btn_pkg;

  localparam int unsigned BTN_MAX = 32;

  typedef logic [BTN_MAX-1:0] btn_vec_t;

  // Byte offsets of the registers the AXI4-Lite slave builds from this block's outputs
  localparam int unsigned LEVEL_OFS        = 32'h00;
  localparam int unsigned PRESS_STICKY_OFS = 32'h04;
  localparam int unsigned REL_STICKY_OFS   = 32'h08;
  localparam int unsigned IRQ_EN_OFS       = 32'h0C;
  localparam int unsigned CNT_CLR_OFS      = 32'h10;
  localparam int unsigned PRESS_CNT_OFS    = 32'h20;

  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(val)) res++;
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce_evt_if.sv
// Bundle between the debounce/event block (slave) and the AXI register slave (master).
interface btn_debounce_evt_if #(
  parameter int unsigned NUM_BTN = 4,
  parameter int unsigned CNT_W   = 8
);
  logic [NUM_BTN-1:0]       btn_raw;
  logic [NUM_BTN-1:0]       irq_en;
  logic                     clr_valid;
  logic [NUM_BTN-1:0]       clr_press;
  logic [NUM_BTN-1:0]       clr_rel;
  logic                     cnt_clr;
  logic [NUM_BTN-1:0]       btn_level;
  logic [NUM_BTN-1:0]       btn_rise;
  logic [NUM_BTN-1:0]       btn_fall;
  logic [NUM_BTN-1:0]       press_sticky;
  logic [NUM_BTN-1:0]       rel_sticky;
  logic [NUM_BTN*CNT_W-1:0] press_cnt;
  logic                     irq;

  modport slave (
    input  btn_raw, irq_en, clr_valid, clr_press, clr_rel, cnt_clr,
    output btn_level, btn_rise, btn_fall, press_sticky, rel_sticky, press_cnt, irq
  );

  modport master (
    output btn_raw, irq_en, clr_valid, clr_press, clr_rel, cnt_clr,
    input  btn_level, btn_rise, btn_fall, press_sticky, rel_sticky, press_cnt, irq
  );
endinterface

// File: rtl/btn_debounce_evt_db_ch.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level and edge pulses.
module btn_db_ch
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = (clog2(DB_CYCLES) < 1) ? 1 : clog2(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic s1_q, s2_q;
  logic level_q, level_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = cnt_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = s2_q;
      cnt_d   = '0;
      rise_d  = s2_q;
      fall_d  = ~s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/btn_debounce_evt.sv
// Per-button debounce channels plus sticky press/release flags, press counters and irq.
module btn_debounce_evt
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN   = 4,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 8
) (
  input logic            clk,
  input logic            reset_p,
  btn_debounce_evt_if.slave bus
);

  logic [NUM_BTN-1:0]       level, rise, fall;
  logic [NUM_BTN-1:0]       press_q, press_d, rel_q, rel_d;
  logic [NUM_BTN-1:0]       press_view, rel_view;
  logic [NUM_BTN-1:0]       clr_p, clr_r;
  logic [NUM_BTN*CNT_W-1:0] cnt_q, cnt_d, cnt_view;
  logic                     irq_q, irq_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_db_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset_p(reset_p),
      .raw    (bus.btn_raw[i]),
      .level  (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  // Flags and counters expose the event in the same cycle as the pulse; the state
  // registers absorb the pulse one edge later, so a coincident clear cannot lose it.
  assign press_view = press_q | rise;
  assign rel_view   = rel_q | fall;

  always_comb begin
    clr_p    = bus.clr_valid ? bus.clr_press : '0;
    clr_r    = bus.clr_valid ? bus.clr_rel   : '0;
    press_d  = (press_q & ~clr_p) | rise;
    rel_d    = (rel_q & ~clr_r) | fall;
    cnt_d    = '0;
    cnt_view = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_view[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(rise[i]);
      cnt_d[i*CNT_W +: CNT_W]    = (bus.cnt_clr ? '0 : cnt_q[i*CNT_W +: CNT_W])
                                   + CNT_W'(rise[i]);
    end
    irq_d = |(press_view & bus.irq_en);
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      press_q <= '0;
      rel_q   <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      press_q <= press_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.btn_level    = level;
  assign bus.btn_rise     = rise;
  assign bus.btn_fall     = fall;
  assign bus.press_sticky = press_view;
  assign bus.rel_sticky   = rel_view;
  assign bus.press_cnt    = cnt_view;
  assign bus.irq          = irq_q;

endmodule

// File: tb/tb_btn_debounce_evt.sv
// Directed bench for btn_debounce_evt with DB_CYCLES=4, NUM_BTN=4, CNT_W=8.
module tb_btn_debounce_evt;

  logic clk = 1'b0;
  logic reset_p;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  btn_debounce_evt_if #(.NUM_BTN(4), .CNT_W(8)) bus ();

  btn_debounce_evt #(
    .NUM_BTN  (4),
    .DB_CYCLES(4),
    .CNT_W    (8)
  ) dut (
    .clk    (clk),
    .reset_p(reset_p),
    .bus    (bus.slave)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset_p       = 1'b1;
    bus.btn_raw   = '0;
    bus.irq_en    = '0;
    bus.clr_valid = 1'b0;
    bus.clr_press = '0;
    bus.clr_rel   = '0;
    bus.cnt_clr   = 1'b0;
    tick(2);
    reset_p = 1'b0;
    tick(1);
    chk("rst_level", 32'(bus.btn_level), 0);
    chk("rst_sticky", 32'({bus.press_sticky, bus.rel_sticky}), 0);
    chk("rst_cnt", bus.press_cnt, 0);
    chk("rst_irq", 32'(bus.irq), 0);

    // Clean press on button 0
    bus.irq_en     = 4'b0001;
    bus.btn_raw[0] = 1'b1;
    tick(5);
    chk("press_e5_level", 32'(bus.btn_level), 0);
    tick(1);
    chk("press_e6_level", 32'(bus.btn_level), 32'b0001);
    chk("press_e6_rise", 32'(bus.btn_rise), 32'b0001);
    chk("press_e6_sticky", 32'(bus.press_sticky), 32'b0001);
    chk("press_e6_cnt", 32'(bus.press_cnt[7:0]), 1);
    chk("press_e6_irq", 32'(bus.irq), 0);
    tick(1);
    chk("press_e7_rise", 32'(bus.btn_rise), 0);
    chk("press_e7_irq", 32'(bus.irq), 1);

    // 3-cycle glitch on button 1 is rejected
    bus.btn_raw[1] = 1'b1;
    tick(3);
    bus.btn_raw[1] = 1'b0;
    tick(6);
    chk("glitch3_level", 32'(bus.btn_level[1]), 0);
    chk("glitch3_sticky", 32'(bus.press_sticky[1]), 0);
    chk("glitch3_cnt", 32'(bus.press_cnt[15:8]), 0);

    // 4-cycle pulse on button 1 is accepted, then released
    bus.btn_raw[1] = 1'b1;
    tick(4);
    bus.btn_raw[1] = 1'b0;
    tick(2);
    chk("pulse4_level", 32'(bus.btn_level[1]), 1);
    chk("pulse4_rise", 32'(bus.btn_rise), 32'b0010);
    tick(3);
    chk("pulse4_e9_level", 32'(bus.btn_level[1]), 1);
    tick(1);
    chk("pulse4_fall", 32'(bus.btn_fall), 32'b0010);
    chk("pulse4_rel_level", 32'(bus.btn_level[1]), 0);
    chk("pulse4_rel_sticky", 32'(bus.rel_sticky), 32'b0010);
    chk("pulse4_cnt", 32'(bus.press_cnt[15:8]), 1);

    // Release button 0
    bus.btn_raw[0] = 1'b0;
    tick(6);
    chk("rel0_fall", 32'(bus.btn_fall), 32'b0001);
    tick(1);

    // W1C race: clear held across the rise edges, set must win
    bus.btn_raw[0] = 1'b1;
    tick(5);
    bus.clr_valid = 1'b1;
    bus.clr_press = 4'b0001;
    tick(1);
    chk("race_rise", 32'(bus.btn_rise), 32'b0001);
    chk("race_sticky_e6", 32'(bus.press_sticky[0]), 1);
    tick(1);
    bus.clr_valid = 1'b0;
    chk("race_sticky_e7", 32'(bus.press_sticky[0]), 1);
    chk("race_cnt", 32'(bus.press_cnt[7:0]), 2);
    bus.clr_valid = 1'b1;
    tick(1);
    bus.clr_valid = 1'b0;
    chk("clr_sticky", 32'(bus.press_sticky[0]), 0);
    chk("clr_irq_lag", 32'(bus.irq), 1);
    tick(1);
    chk("clr_irq", 32'(bus.irq), 0);

    // clr_rel ignored without clr_valid, applied with it
    bus.clr_rel = 4'b0011;
    tick(1);
    chk("clr_unqual", 32'(bus.rel_sticky), 32'b0011);
    bus.clr_valid = 1'b1;
    tick(1);
    bus.clr_valid = 1'b0;
    bus.clr_press = '0;
    bus.clr_rel   = '0;
    chk("clr_rel", 32'(bus.rel_sticky), 0);
    bus.btn_raw[0] = 1'b0;
    tick(8);

    // Counter wrap on button 2
    for (int i = 0; i < 255; i++) begin
      bus.btn_raw[2] = 1'b1;
      tick(7);
      bus.btn_raw[2] = 1'b0;
      tick(7);
    end
    chk("cnt_255", 32'(bus.press_cnt[23:16]), 255);
    bus.btn_raw[2] = 1'b1;
    tick(7);
    bus.btn_raw[2] = 1'b0;
    tick(7);
    chk("cnt_wrap", 32'(bus.press_cnt[23:16]), 0);

    // cnt_clr coincident with a press
    bus.btn_raw[2] = 1'b1;
    tick(5);
    bus.cnt_clr = 1'b1;
    tick(1);
    bus.cnt_clr = 1'b0;
    chk("cntclr_e6", 32'(bus.press_cnt[23:16]), 1);
    chk("cntclr_others", 32'(bus.press_cnt[15:0]), 0);
    tick(1);
    chk("cntclr_e7", 32'(bus.press_cnt[23:16]), 1);
    bus.btn_raw[2] = 1'b0;
    tick(8);

    // Reset two cycles into debounce on button 3
    bus.btn_raw[3] = 1'b1;
    tick(4);
    reset_p = 1'b1;
    tick(1);
    chk("mrst_level", 32'(bus.btn_level), 0);
    chk("mrst_sticky", 32'({bus.press_sticky, bus.rel_sticky}), 0);
    chk("mrst_cnt", bus.press_cnt, 0);
    chk("mrst_irq", 32'(bus.irq), 0);
    reset_p = 1'b0;
    tick(1);
    chk("mrst_no_pulse", 32'({bus.btn_rise, bus.btn_fall}), 0);
    tick(4);
    chk("mrst_e5_level", 32'(bus.btn_level), 0);
    tick(1);
    chk("mrst_e6_level", 32'(bus.btn_level), 32'b1000);
    chk("mrst_e6_rise", 32'(bus.btn_rise), 32'b1000);

    // All four buttons at once
    bus.btn_raw = '0;
    tick(8);
    bus.cnt_clr   = 1'b1;
    bus.clr_valid = 1'b1;
    bus.clr_press = 4'b1111;
    bus.clr_rel   = 4'b1111;
    tick(1);
    bus.cnt_clr   = 1'b0;
    bus.clr_valid = 1'b0;
    tick(1);
    chk("multi_pre_sticky", 32'({bus.press_sticky, bus.rel_sticky}), 0);
    bus.btn_raw = 4'b1111;
    tick(6);
    chk("multi_rise", 32'(bus.btn_rise), 32'b1111);
    chk("multi_level", 32'(bus.btn_level), 32'b1111);
    chk("multi_sticky", 32'(bus.press_sticky), 32'b1111);
    chk("multi_cnt", bus.press_cnt, 32'h0101_0101);
    tick(1);
    chk("multi_rise_end", 32'(bus.btn_rise), 0);
    chk("multi_irq", 32'(bus.irq), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
